// File: rtl/RSA_pkg.sv
// Shared RSA datapath types.
// MOD_WIDTH         : operand width of the modular arithmetic (256 bits).
// IntType           : 32-bit unsigned integer used for exponents and counters.
// RSATwoPowerModIn  : request payload {power, modulus}.
// RSATwoPowerModOut : result payload {value} = 2^power mod modulus.
package RSA_pkg;

    localparam int MOD_WIDTH = 256;

    typedef logic [31:0] IntType;

    typedef struct packed {
        IntType                 power;
        logic [MOD_WIDTH-1:0]   modulus;
    } RSATwoPowerModIn;

    typedef struct packed {
        logic [MOD_WIDTH-1:0]   value;
    } RSATwoPowerModOut;

endpackage

// File: rtl/rsa_mod_double.sv
// One double-and-reduce step: o_acc = (2 * i_acc) mod i_modulus.
// Valid when i_acc < i_modulus, so 2 * i_acc < 2 * i_modulus and a single
// conditional subtraction brings the result back into range.
// Ports:
//   i_acc     : current accumulator (MOD_WIDTH bits)
//   i_modulus : modulus (MOD_WIDTH bits)
//   o_acc     : reduced doubled accumulator (MOD_WIDTH bits)
module rsa_mod_double
    import RSA_pkg::*;
(
    input  logic [MOD_WIDTH-1:0] i_acc,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic [MOD_WIDTH-1:0] o_acc
);

    logic [MOD_WIDTH:0]   w_t;
    logic [MOD_WIDTH-1:0] w_diff;
    logic                 w_ge;

    // The doubled value needs one extra bit so the compare sees the carry.
    assign w_t    = {i_acc, 1'b0};
    assign w_ge   = (w_t >= {1'b0, i_modulus});
    // Subtraction modulo 2^MOD_WIDTH gives the same low bits as the full one.
    assign w_diff = w_t[MOD_WIDTH-1:0] - i_modulus;
    assign o_acc  = w_ge ? w_diff : w_t[MOD_WIDTH-1:0];

endmodule

// File: rtl/rsa_two_power_mod.sv
// Computes 2^power mod modulus (R^2 mod N precompute for the Montgomery stage)
// by repeated double-and-reduce, one step per clock.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   i_valid  : request valid
//   i_ready  : block can accept a request (high only in IDLE)
//   i_in     : request {power, modulus}
//   o_valid  : result valid (high only in DONE)
//   o_ready  : downstream accepts the result
//   o_out    : result 2^power mod modulus, held while o_valid && !o_ready
// Latency: request accepted on edge T gives o_valid after edge T+power+1.
module rsa_two_power_mod
    import RSA_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  RSATwoPowerModIn  i_in,
    output logic             o_valid,
    input  logic             o_ready,
    output RSATwoPowerModOut o_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [MOD_WIDTH-1:0] r_modulus;
    logic [MOD_WIDTH-1:0] r_acc;
    IntType               r_counter;
    logic [MOD_WIDTH-1:0] r_out;
    logic [MOD_WIDTH-1:0] w_acc_next;

    rsa_mod_double u_mod_double (
        .i_acc     (r_acc),
        .i_modulus (r_modulus),
        .o_acc     (w_acc_next)
    );

    // Handshake flags come straight from the state register.
    assign i_ready     = (r_state == IDLE);
    assign o_valid     = (r_state == DONE);
    assign o_out.value = r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_modulus <= '0;
            r_acc     <= '0;
            r_counter <= '0;
            r_out     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_modulus <= i_in.modulus;
                        r_counter <= i_in.power;
                        r_acc     <= {{(MOD_WIDTH-1){1'b0}}, 1'b1};
                        r_state   <= CALC;
                    end
                end
                CALC: begin
                    // Counter == 0 costs one extra cycle, so power == 0 still
                    // passes through CALC and yields latency 1.
                    if (r_counter != '0) begin
                        r_acc     <= w_acc_next;
                        r_counter <= r_counter - 32'd1;
                    end else begin
                        r_out   <= r_acc;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_two_power_mod.sv
module tb_rsa_two_power_mod;
    import RSA_pkg::*;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic             i_ready;
    RSATwoPowerModIn  i_in;
    logic             o_valid;
    logic             o_ready;
    RSATwoPowerModOut o_out;

    logic [MOD_WIDTH-1:0] exp_q[$];
    int tests_run;
    int tests_failed;

    rsa_two_power_mod dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_in    (i_in),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_out   (o_out)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1);
    end

    // Reference model: square-and-multiply on 64-bit integers (modulus < 2^32).
    function automatic logic [MOD_WIDTH-1:0] model_pow2(input int unsigned p, input logic [31:0] m);
        longint unsigned r;
        longint unsigned b;
        int unsigned     e;
        r = 64'd1 % m;
        b = 64'd2 % m;
        e = p;
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return {224'd0, r[31:0]};
    endfunction

    // Driver: waits for i_ready, presents one request, returns at the negedge
    // after the accepting posedge with the input bus scrambled.
    task automatic drive_req(input logic [31:0] p, input logic [MOD_WIDTH-1:0] m, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!i_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (!i_ready) begin
            ok = 1'b0;
            return;
        end
        i_valid      = 1'b1;
        i_in.power   = p;
        i_in.modulus = m;
        @(negedge clk);
        i_valid      = 1'b0;
        i_in.power   = $urandom;
        i_in.modulus = {8{$urandom}};
    endtask

    // Counts negedges until o_valid is seen, up to budget.
    task automatic wait_out(input int budget, output int lat);
        lat = 0;
        while (!o_valid && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        i_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_i_ready got=%b exp=1", i_ready); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        tests_run++; if (o_out.value !== '0) begin tests_failed++; $display("FAIL reset_o_out got=%0h exp=0", o_out.value); end
    endtask

    // Single request, result consumed immediately; checks latency and value.
    task automatic test_single(input string name, input logic [31:0] p, input logic [MOD_WIDTH-1:0] m,
                               input logic [MOD_WIDTH-1:0] expv, input bit noisy);
        bit ok;
        int lat;
        logic [MOD_WIDTH-1:0] e;
        exp_q.push_back(expv);
        o_ready = 1'b1;
        drive_req(p, m, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL %s_accept got=timeout exp=accepted", name); end
        if (noisy) begin
            // Inputs toggle while busy; they must be ignored.
            i_valid = 1'b1;
            i_in.power = 32'd1;
            i_in.modulus = 256'd3;
            @(negedge clk);
            i_valid = 1'b0;
            wait_out(p + 20, lat);
            lat = lat + 1;
        end else begin
            wait_out(p + 20, lat);
        end
        tests_run++; if (lat !== int'(p) + 1 || !o_valid) begin tests_failed++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, p + 1); end
        e = exp_q.pop_front();
        tests_run++; if (o_out.value !== e) begin tests_failed++; $display("FAIL %s_value got=%0h exp=%0h", name, o_out.value, e); end
        @(negedge clk);
        tests_run++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_release got=o_valid:%b,i_ready:%b exp=0,1", name, o_valid, i_ready); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [MOD_WIDTH-1:0] e;
        exp_q.push_back(256'd4);
        e = exp_q.pop_front();
        o_ready = 1'b0;
        drive_req(32'd5, 256'd7, ok);
        wait_out(40, lat);
        tests_run++; if (lat !== 6 || !o_valid) begin tests_failed++; $display("FAIL bp_latency got=%0d exp=6", lat); end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (o_valid !== 1'b1 || o_out.value !== e || i_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle=%0d got=o_valid:%b,o_out:%0h,i_ready:%b exp=1,%0h,0", k, o_valid, o_out.value, i_ready, e);
            end
            @(negedge clk);
        end
        o_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release got=o_valid:%b,i_ready:%b exp=0,1", o_valid, i_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok1;
        bit ok2;
        int lat;
        logic [MOD_WIDTH-1:0] e;
        o_ready = 1'b1;
        exp_q.push_back(256'd4);
        exp_q.push_back(256'd3);
        fork
            begin
                drive_req(32'd5, 256'd7, ok1);
                drive_req(32'd3, 256'd5, ok2);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_out(60, lat);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                    tests_run++;
                    if (!o_valid || o_out.value !== e) begin
                        tests_failed++;
                        $display("FAIL b2b_result idx=%0d got=%0h valid=%b exp=%0h", k, o_out.value, o_valid, e);
                    end
                    @(negedge clk);
                end
            end
        join
        tests_run++; if (!ok1 || !ok2) begin tests_failed++; $display("FAIL b2b_accept got=%b%b exp=11", ok1, ok2); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_random();
        int unsigned p;
        logic [31:0] m;
        for (int k = 0; k < 8; k++) begin
            p = $urandom_range(0, 40);
            m = $urandom_range(2, 32'hFFFF_FFFF);
            test_single($sformatf("rand%0d", k), p, {224'd0, m}, model_pow2(p, m), 1'b0);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit rose;
        exp_q.push_back(model_pow2(100, 13));
        o_ready = 1'b1;
        drive_req(32'd100, 256'd13, ok);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tests_run++; if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_out.value !== '0) begin tests_failed++; $display("FAIL abort_reset got=i_ready:%b,o_valid:%b,o_out:%0h exp=1,0,0", i_ready, o_valid, o_out.value); end
        rose = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (o_valid) rose = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (rose !== 1'b0) begin tests_failed++; $display("FAIL abort_no_output got=%b exp=0", rose); end
        test_single("after_abort", 32'd4, 256'd13, 256'd3, 1'b0);
    endtask

    initial begin
        logic [MOD_WIDTH-1:0] big_mod;
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single("p0_m13", 32'd0, 256'd13, 256'd1, 1'b0);
        test_single("p4_m13", 32'd4, 256'd13, 256'd3, 1'b1);
        big_mod = '1;
        big_mod = big_mod - 256'd188;
        test_single("p256_big", 32'd256, big_mod, 256'd189, 1'b0);
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
